control_unit: RTL
=================

# control_unit

Hardwired Mini SRC control sequencer: the block that drives the datapath's control inputs, replacing bench-driven stimulus. It is a Moore FSM that steps through fetch (T0–T2) and a per-opcode execute sequence (T3–T7), decoding from the IR word fed back from the datapath. It sits beside `DataPath` in the CPU top level, and its outputs connect one-to-one to the datapath control ports.

## Interface
- No parameters; encodings are fixed by the shared package.
- `clk` in 1: rising-edge clock.
- `clr` in 1: asynchronous, active-high reset.
- `stop` in 1: halt request, sampled at instruction boundaries.
- `ir` in 32: IR contents. Fields: op = [31:27], Ra = [26:23], Rb = [22:19], Rc = [18:15], C = [18:0].
- `con_ff` in 1: branch-condition flip-flop from the datapath.
- `alu_control` out 5: ALU operation code.
- Register-file control, each 1 bit out: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `R15en`.
- Bus sources, each 1 bit out: `Pout`, `MDROut`, `HIout`, `LOout`, `ZHIout`, `ZLOout`, `Cout`.
- Register enables, each 1 bit out: `Pen`, `incPC`, `IRen`, `MARen`, `MDRen`, `Yen`, `ZHIen`, `ZLOen`, `HIen`, `LOen`, `ConIn`.
- Memory control, each 1 bit out: `Read`, `Write`.
- `run` out 1: high while executing; low in RESET and HALT.

## Operation
- States: RESET, T0–T7, HALT.
- Every output is decoded from state plus `ir[31:27]` only, with no input-to-output combinational path except `con_ff` in branch T6.
- Any control output not listed for a step is 0. `alu_control` is 0 when unused.
- Fetch:
  - T0: Pout, MARen, incPC.
  - T1: Read, MDRen.
  - T2: MDROut, IRen.
- Reg ALU ops, op 00011–01011:
  - T3: Grb, Rout, Yen.
  - T4: Grc, Rout, ZLOen, alu = op.
  - T5: ZLOout, Gra, Rin.
- Immediate ops addi/andi/ori, op 01100/01101/01110:
  - As reg ALU, except T4 uses Cout in place of Grc/Rout.
  - alu = 00011, 01010, 01011 respectively.
- ldi, op 00001:
  - T3: Grb, BAout, Yen.
  - T4: Cout, alu = 00011, ZLOen.
  - T5: ZLOout, Gra, Rin.
- ld, op 00000:
  - T3–T4 as ldi.
  - T5: ZLOout, MARen.
  - T6: Read, MDRen.
  - T7: MDROut, Gra, Rin.
- st, op 00010:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRen (Read = 0).
  - T7: Write.
- mul/div, op 01111/10000:
  - T3: Gra, Rout, Yen.
  - T4: Grb, Rout, alu = op, ZHIen, ZLOen.
  - T5: ZLOout, LOen.
  - T6: ZHIout, HIen.
- neg/not, op 10001/10010:
  - T3: Grb, Rout, alu = op, ZLOen.
  - T4: ZLOout, Gra, Rin.
- Branch, op 10011:
  - T3: Gra, Rout, ConIn.
  - T4: Pout, Yen.
  - T5: Cout, alu = 00011, ZLOen.
  - T6: ZLOout and Pen only if `con_ff` = 1; otherwise no outputs.
- jr, op 10100:
  - T3: Gra, Rout, Pen.
- jal, op 10101:
  - T3: Pout, R15en.
  - T4: Gra, Rout, Pen.
- mfhi/mflo, op 11000/11001:
  - T3: HIout or LOout, plus Gra, Rin.
- nop, in, out, and undefined opcodes: T2 goes directly to T0.
- halt, op 11011: T2 goes to HALT.
- HALT: all outputs 0 and `run` = 0. HALT is left only via `clr`.
- `stop`:
  - Sampled on the clock edge that ends an instruction's last step.
  - If high, the FSM goes to HALT instead of T0.
  - The in-flight instruction always completes.

## Timing
- `clr` asserted: state forces to RESET immediately. All outputs, including `run`, go to 0 without waiting for a clock edge.
- First edge after `clr` deasserts: RESET goes to T0, and `run` = 1 from T0 onward.
- One step per cycle. Cycles per instruction, including fetch:
  - 3: nop.
  - 4: jr, mfhi, mflo.
  - 5: neg, not, jal.
  - 6: ALU, immediate, ldi.
  - 7: mul, div, branch.
  - 8: ld, st.
- Memory is fixed single-cycle. The Read step's MDRen captures Mdatain at the end of that same cycle.
- `con_ff` is valid in T6 because ConIn was clocked at the end of T3.
- `clr` mid-instruction: the instruction is abandoned and no further strobes are issued.

## Structure
- Package `mini_src_pkg` holds:
  - Opcode localparams.
  - ALU code localparams (ADD = 00011, AND = 01010, OR = 01011).
  - The state enum.
  - IR field bit positions.
- Sub-module `control_decode`: combinational mapping from `ir[31:27]` to an instruction-class enum (ALU, IMM, LD, LDI, ST, MULDIV, UNARY, BR, JR, JAL, MFHI, MFLO, NOP, HALT) plus the mapped `alu_control`.
- `control_unit` contains the state register, next-state logic, and the per-class output decode.

## Test plan
- `clr` pulse mid-T4 of add → all outputs and `run` go to 0 immediately; after release, T0 shows Pout = MARen = incPC = 1.
- `ir` = 0x19890000 (add r3,r1,r2) → T3 Grb+Rout+Yen, T4 Grc+Rout+ZLOen with alu = 00011, T5 ZLOout+Gra+Rin, then T0.
- `ir` = 0x09000065 (ldi r2,0x65(r0)) → T3 BAout+Grb+Yen, T4 Cout+ZLOen with alu = 00011, T5 Gra+Rin; 6 cycles total.
- `ir` = 0x9A800019 (brzr r5,25): `con_ff` = 1 → T6 ZLOout+Pen; `con_ff` = 0 → T6 all outputs 0; T0 follows in both cases.
- `ir` = 0xD8000000 (halt) → HALT after T2 with `run` = 0 held for 20 cycles; `clr` then restarts at T0.
- `stop` raised during T4 of an ld (op 00000) → T5–T7 still issue, then HALT instead of T0.

Source files
------------

// File: rtl/mini_src_pkg.sv
// Shared Mini SRC encodings: opcodes, ALU codes, IR field positions, FSM states,
// instruction classes and the packed control word driven onto the datapath.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b01010;
  localparam logic [4:0] ALU_OR   = 5'b01011;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C_MSB  = 18;
  localparam int IR_C_LSB  = 0;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY,
    C_BR, C_JR, C_JAL, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic [4:0] alu_control;
    logic Gra, Grb, Grc, Rin, Rout, BAout, R15en;
    logic Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout;
    logic Pen, incPC, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen, ConIn;
    logic Read, Write;
  } ctrl_t;

  // Final execute step of each class; the stop request is honoured on the edge leaving it.
  function automatic state_t last_step(input iclass_t c);
    case (c)
      C_ALU, C_IMM, C_LDI:  return S_T5;
      C_LD, C_ST:           return S_T7;
      C_MULDIV, C_BR:       return S_T6;
      C_UNARY, C_JAL:       return S_T4;
      C_JR, C_MFHI, C_MFLO: return S_T3;
      default:              return S_T2;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/condition feedback and halt request in,
// the full set of datapath strobes and the run flag out.
interface control_unit_if;
  import mini_src_pkg::*;

  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic [4:0]  alu_control;
  logic Gra, Grb, Grc, Rin, Rout, BAout, R15en;
  logic Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout;
  logic Pen, incPC, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen, ConIn;
  logic Read, Write;
  logic run;

  modport master (
    input  ir, con_ff, stop,
    output alu_control,
    output Gra, Grb, Grc, Rin, Rout, BAout, R15en,
    output Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout,
    output Pen, incPC, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen, ConIn,
    output Read, Write, run
  );

  modport slave (
    output ir, con_ff, stop,
    input  alu_control,
    input  Gra, Grb, Grc, Rin, Rout, BAout, R15en,
    input  Pout, MDROut, HIout, LOout, ZHIout, ZLOout, Cout,
    input  Pen, incPC, IRen, MARen, MDRen, Yen, ZHIen, ZLOen, HIen, LOen, ConIn,
    input  Read, Write, run
  );
endinterface

// File: rtl/control_decode.sv
// Opcode to instruction-class map plus the ALU code each class drives.
// Purely combinational.
module control_decode
  import mini_src_pkg::*;
(
  input  logic [4:0] op,
  output iclass_t    iclass,
  output logic [4:0] alu_op
);

  always_comb begin
    iclass = C_NOP;
    alu_op = ALU_NONE;
    if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) begin
      iclass = C_ALU;
      alu_op = op;
    end else begin
      case (op)
        OP_LD:   begin iclass = C_LD;     alu_op = ALU_ADD; end
        OP_LDI:  begin iclass = C_LDI;    alu_op = ALU_ADD; end
        OP_ST:   begin iclass = C_ST;     alu_op = ALU_ADD; end
        OP_ADDI: begin iclass = C_IMM;    alu_op = ALU_ADD; end
        OP_ANDI: begin iclass = C_IMM;    alu_op = ALU_AND; end
        OP_ORI:  begin iclass = C_IMM;    alu_op = ALU_OR;  end
        OP_MUL,
        OP_DIV:  begin iclass = C_MULDIV; alu_op = op;      end
        OP_NEG,
        OP_NOT:  begin iclass = C_UNARY;  alu_op = op;      end
        OP_BR:   begin iclass = C_BR;     alu_op = ALU_ADD; end
        OP_JR:   iclass = C_JR;
        OP_JAL:  iclass = C_JAL;
        OP_MFHI: iclass = C_MFHI;
        OP_MFLO: iclass = C_MFLO;
        OP_HALT: iclass = C_HALT;
        // in, out, nop and unassigned opcodes all retire straight after fetch
        default: iclass = C_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: Moore FSM for fetch T0-T2 and per-class execute T3-T7.
// Outputs depend on state and opcode only, except con_ff gating the branch T6 strobes.
module control_unit
  import mini_src_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);

  state_t     state, state_nxt;
  iclass_t    iclass;
  logic [4:0] alu_op;
  ctrl_t      c;

  control_decode u_decode (
    .op     (bus.ir[IR_OP_MSB:IR_OP_LSB]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: begin
        if (state == S_T2 && iclass == C_HALT)
          state_nxt = S_HALT;
        else if (state == last_step(iclass))
          state_nxt = bus.stop ? S_HALT : S_T0;
        else
          state_nxt = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_T0: begin c.Pout = 1'b1; c.MARen = 1'b1; c.incPC = 1'b1; end
      S_T1: begin c.Read = 1'b1; c.MDRen = 1'b1; end
      S_T2: begin c.MDROut = 1'b1; c.IRen = 1'b1; end
      S_T3: begin
        case (iclass)
          C_ALU, C_IMM: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yen = 1'b1; end
          C_LD, C_LDI, C_ST: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yen = 1'b1; end
          C_MULDIV: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yen = 1'b1; end
          C_UNARY: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.ZLOen = 1'b1; c.alu_control = alu_op;
          end
          C_BR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.ConIn = 1'b1; end
          C_JR:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.Pen = 1'b1; end
          C_JAL:  begin c.Pout = 1'b1; c.R15en = 1'b1; end
          C_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU: begin
            c.Grc = 1'b1; c.Rout = 1'b1; c.ZLOen = 1'b1; c.alu_control = alu_op;
          end
          C_IMM, C_LD, C_LDI, C_ST: begin
            c.Cout = 1'b1; c.ZLOen = 1'b1; c.alu_control = alu_op;
          end
          C_MULDIV: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.ZHIen = 1'b1; c.ZLOen = 1'b1;
            c.alu_control = alu_op;
          end
          C_UNARY: begin c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_BR:    begin c.Pout = 1'b1; c.Yen = 1'b1; end
          C_JAL:   begin c.Gra = 1'b1; c.Rout = 1'b1; c.Pen = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU, C_IMM, C_LDI: begin c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_LD, C_ST: begin c.ZLOout = 1'b1; c.MARen = 1'b1; end
          C_MULDIV:   begin c.ZLOout = 1'b1; c.LOen = 1'b1; end
          C_BR: begin c.Cout = 1'b1; c.ZLOen = 1'b1; c.alu_control = alu_op; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD:     begin c.Read = 1'b1; c.MDRen = 1'b1; end
          C_ST:     begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRen = 1'b1; end
          C_MULDIV: begin c.ZHIout = 1'b1; c.HIen = 1'b1; end
          // con_ff was latched at the end of T3, so it is settled here
          C_BR: begin c.ZLOout = bus.con_ff; c.Pen = bus.con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD: begin c.MDROut = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_ST: c.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.alu_control = c.alu_control;
  assign bus.Gra    = c.Gra;
  assign bus.Grb    = c.Grb;
  assign bus.Grc    = c.Grc;
  assign bus.Rin    = c.Rin;
  assign bus.Rout   = c.Rout;
  assign bus.BAout  = c.BAout;
  assign bus.R15en  = c.R15en;
  assign bus.Pout   = c.Pout;
  assign bus.MDROut = c.MDROut;
  assign bus.HIout  = c.HIout;
  assign bus.LOout  = c.LOout;
  assign bus.ZHIout = c.ZHIout;
  assign bus.ZLOout = c.ZLOout;
  assign bus.Cout   = c.Cout;
  assign bus.Pen    = c.Pen;
  assign bus.incPC  = c.incPC;
  assign bus.IRen   = c.IRen;
  assign bus.MARen  = c.MARen;
  assign bus.MDRen  = c.MDRen;
  assign bus.Yen    = c.Yen;
  assign bus.ZHIen  = c.ZHIen;
  assign bus.ZLOen  = c.ZLOen;
  assign bus.HIen   = c.HIen;
  assign bus.LOen   = c.LOen;
  assign bus.ConIn  = c.ConIn;
  assign bus.Read   = c.Read;
  assign bus.Write  = c.Write;
  assign bus.run    = (state != S_RESET) && (state != S_HALT);

endmodule
